// File: rtl/uart_param.sv
// Parameterised UART: one TX and one RX channel sharing a frame format.
// Define UART_PARITY_EN to add a parity bit (parity_odd selects odd/even).
`timescale 1ns/1ps
module uart_param #(
  parameter int CLK_FREQ  = 100_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_odd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for tx_start / rx falling edge
  // S_START | start bit
  // S_DATA  | payload bits, LSB first
  // S_PARITY| parity bit (UART_PARITY_EN only)
  // S_STOP  | stop bit(s)
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  state_t                 tx_state;
  logic [CW-1:0]          tx_cnt;
  logic [BW-1:0]          tx_bit;
  logic                   tx_stop;
  logic [DATA_BITS-1:0]   tx_sh;
`ifdef UART_PARITY_EN
  logic                   tx_par;
`endif

  logic tx_bit_end, tx_frame_end, tx_accept;
  assign tx_bit_end   = (tx_cnt == CNT_LAST);
  assign tx_frame_end = (tx_state == S_STOP) && (tx_stop == STOP_LAST) && tx_bit_end;
  // accepting in the final stop cycle gives back-to-back frames with no idle gap
  assign tx_accept    = tx_start && ((tx_state == S_IDLE) || tx_frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_sh    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_done <= (tx_state == S_STOP) && (tx_stop == STOP_LAST) && (tx_cnt == CNT_PRE);
      if (tx_accept) begin
        tx_state <= S_START;
        tx_cnt   <= '0;
        tx_sh    <= tx_data;
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
`ifdef UART_PARITY_EN
        tx_par   <= (^tx_data) ^ parity_odd;
`endif
      end else if (tx_state != S_IDLE) begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
        if (tx_bit_end) begin
          case (tx_state)
            S_START: begin
              tx_state <= S_DATA;
              tx_bit   <= '0;
              tx       <= tx_sh[0];
            end
            S_DATA: begin
              if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                tx_state <= S_PARITY;
                tx       <= tx_par;
`else
                tx_state <= S_STOP;
                tx_stop  <= 1'b0;
                tx       <= 1'b1;
`endif
              end else begin
                tx_bit <= tx_bit + 1'b1;
                tx_sh  <= tx_sh >> 1;
                tx     <= tx_sh[1];
              end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
              tx_state <= S_STOP;
              tx_stop  <= 1'b0;
              tx       <= 1'b1;
            end
`endif
            S_STOP: begin
              if (tx_stop == STOP_LAST) begin
                tx_state <= S_IDLE;
                tx_busy  <= 1'b0;
              end else begin
                tx_stop <= 1'b1;
              end
            end
            default: tx_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  state_t                 rx_state;
  logic [CW-1:0]          rx_cnt;
  logic [BW-1:0]          rx_bit;
  logic [DATA_BITS-1:0]   rx_sh;
  logic                   rx_s1, rx_s2, rx_prev;
`ifdef UART_PARITY_EN
  logic                   rx_perr;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign rx_parity_err     = 1'b0;
`endif

  logic rx_fall, rx_bit_end;
  assign rx_fall    = rx_prev & ~rx_s2;
  assign rx_bit_end = (rx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          // mid start bit: a line already back high was a glitch
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_perr  <= rx_s2 ^ (^rx_sh) ^ parity_odd;
            rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (rx_bit_end) begin
            rx_cnt       <= '0;
            rx_state     <= S_IDLE;
            rx_done      <= 1'b1;
            rx_data      <= rx_sh;
            rx_frame_err <= ~rx_s2;
`ifdef UART_PARITY_EN
            rx_parity_err <= rx_perr;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at DIV=10, 8 data bits, 1 stop bit.
`timescale 1ns/1ps
module tb_uart_param;
  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       parity_odd = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx;
  logic       tx, tx_busy, tx_done, rx_done, rx_frame_err, rx_parity_err;
  logic [7:0] rx_data;

  assign rx = loop ? tx : rx_drv;

  uart_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .parity_odd(parity_odd), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx(rx), .rx_data(rx_data), .rx_done(rx_done),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int txd_cnt = 0;
  logic [7:0] rx_log [0:15];
  logic       fe_log [0:15];
  logic       pe_log [0:15];

  always @(negedge clk) begin
    if (rx_done && rx_cnt < 16) begin
      rx_log[rx_cnt] = rx_data;
      fe_log[rx_cnt] = rx_frame_err;
      pe_log[rx_cnt] = rx_parity_err;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_done) txd_cnt = txd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int target, input int budget);
    for (int i = 0; i < budget && rx_cnt < target; i++) tick(1);
    chk("rx_count", rx_cnt, target);
  endtask

  task automatic chk_rx(input int idx, input logic [7:0] d, input logic fe, input logic pe);
    if (idx >= 0 && idx < 16 && idx < rx_cnt) begin
      chk("rx_data", rx_log[idx], d);
      chk("rx_frame_err", fe_log[idx], fe);
      chk("rx_parity_err", pe_log[idx], pe);
    end else begin
      chk("rx_missing", rx_cnt, idx + 1);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic stop_v, input logic pbit);
`ifdef UART_PARITY_EN
    mk = {stop_v, pbit, d, 1'b0};
`else
    mk = {1'b0 & pbit, stop_v, d, 1'b0};
`endif
  endfunction

  task automatic send_rx(input logic [10:0] fr);
    for (int i = 0; i < NB; i++) begin
      rx_drv = fr[i];
      tick(DIV);
    end
    rx_drv = 1'b1;
    tick(DIV);
  endtask

  // Entered one cycle after the accepting edge; checks every cycle of the frame.
  task automatic check_tx_frame(input logic [7:0] d, input logic podd, input bit poke,
                                input bit chain, input logic [7:0] next_d);
    logic [10:0] fr;
    fr = mk(d, 1'b1, (^d) ^ podd);
    tx_start = 1'b0;
    tx_data  = ~d;
    if (poke) parity_odd = ~podd;
    for (int i = 0; i < NB * DIV; i++) begin
      chk("tx_bit", tx, fr[i / DIV]);
      chk("tx_busy", tx_busy, 1'b1);
      chk("tx_done", tx_done, i == NB * DIV - 1);
      if (poke && i == 45) tx_start = 1'b1;
      if (poke && i == 46) tx_start = 1'b0;
      if (chain && i == NB * DIV - 1) begin
        tx_start = 1'b1;
        tx_data  = next_d;
      end
      tick(1);
    end
    if (poke) parity_odd = podd;
    if (!chain) begin
      chk("tx_idle", tx, 1'b1);
      chk("tx_busy_end", tx_busy, 1'b0);
      chk("tx_done_end", tx_done, 1'b0);
    end
  endtask

  int txd0, rx0;

  initial begin
    #2 rst_n = 1'b0;
    #2;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_done", rx_done, 1'b0);
    chk("rst_frame_err", rx_frame_err, 1'b0);
    chk("rst_parity_err", rx_parity_err, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // single frame, with an ignored tx_start and input changes mid-frame
    tx_data = 8'hA5; parity_odd = 1'b0; tx_start = 1'b1;
    tick(1);
    check_tx_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(5);
    chk("tx_done_pulses", txd_cnt, 1);
    chk("rx_quiet", rx_cnt, 0);

    // loopback, back-to-back
    loop = 1'b1;
    tick(2);
    tx_data = 8'h3C; tx_start = 1'b1;
    tick(1);
    check_tx_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3);
    check_tx_frame(8'hC3, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_rx(2, 100);
    chk_rx(0, 8'h3C, 1'b0, 1'b0);
    chk_rx(1, 8'hC3, 1'b0, 1'b0);
    chk("tx_done_b2b", txd_cnt, 3);
    loop = 1'b0;

    // glitch rejection then a valid frame
    tick(5);
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(30);
    chk("glitch_no_done", rx_cnt, 2);
    send_rx(mk(8'h55, 1'b1, ^8'h55));
    wait_rx(3, 40);
    chk_rx(2, 8'h55, 1'b0, 1'b0);

    // stop bit low
    send_rx(mk(8'h81, 1'b0, ^8'h81));
    wait_rx(4, 40);
    chk_rx(3, 8'h81, 1'b1, 1'b0);
    tick(DIV);

`ifdef UART_PARITY_EN
    parity_odd = 1'b0;
    send_rx(mk(8'h07, 1'b1, 1'b0));
    wait_rx(5, 40);
    chk_rx(4, 8'h07, 1'b0, 1'b1);
    send_rx(mk(8'h07, 1'b1, 1'b1));
    wait_rx(6, 40);
    chk_rx(5, 8'h07, 1'b0, 1'b0);
`endif

    // reset in the middle of a looped-back frame
    txd0 = txd_cnt;
    rx0  = rx_cnt;
    loop = 1'b1;
    tx_data = 8'hA5; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(40);
    chk("mid_frame_tx_low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_rx_data", rx_data, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("abort_no_tx_done", txd_cnt, txd0);
    chk("abort_no_rx_done", rx_cnt, rx0);
    chk("post_rst_idle", tx, 1'b1);
    tx_data = 8'h5A; tx_start = 1'b1;
    tick(1);
    check_tx_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_rst_tx_done", txd_cnt, txd0 + 1);
    wait_rx(rx0 + 1, 60);
    chk_rx(rx0, 8'h5A, 1'b0, 1'b0);
    loop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter CLK_FREQ, 100_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, line bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer divide, DIV >= 4).
REQ-003 Parameter DATA_BITS, 8, payload width, legal 5..9.
REQ-004 Parameter STOP_BITS, 1, stop bits transmitted, legal 1 or 2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 tx_start  input  1  request to send tx_data.
REQ-008 tx_data  input  DATA_BITS  payload to transmit.
REQ-009 parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-010 tx  output  1  serial line out, idle high.
REQ-011 tx_busy  output  1  high from accepted start until frame end.
REQ-012 tx_done  output  1  one-cycle pulse at end of final stop bit.
REQ-013 rx  input  1  serial line in, asynchronous to clk.
REQ-014 rx_data  output  DATA_BITS  last received payload, held until next rx_done.
REQ-015 rx_done  output  1  one-cycle pulse when a frame completes.
REQ-016 rx_frame_err  output  1  valid with rx_done; stop bit sampled low.
REQ-017 rx_parity_err  output  1  valid with rx_done; parity mismatch.

Function
REQ-018 Frame SHALL be start (0), DATA_BITS LSB first, optional parity, STOP_BITS stop (1); every bit exactly DIV clocks.
REQ-019 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on tx_start, START->DATA after DIV, DATA->PARITY (or STOP) after DATA_BITS bits, STOP->IDLE after STOP_BITS*DIV.
REQ-020 tx_data and parity_odd SHALL be latched on the accepting cycle; later changes do not affect the frame.
REQ-021 tx SHALL go low the cycle after tx_start is accepted; tx_busy rises the same cycle.
REQ-022 tx_start while tx_busy SHALL be ignored, not queued; tx_start in the tx_done cycle is accepted (back-to-back frames, no idle gap).
REQ-023 TX and RX baud counters SHALL be independent; each restarts at 0 on frame start.
REQ-024 rx SHALL pass a two-flop synchroniser; all RX decisions use the synchronised value.
REQ-025 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised high-to-low.
REQ-026 START samples at DIV/2; if rx high, return to IDLE with no rx_done (glitch reject).
REQ-027 DATA, PARITY, STOP bits sampled at mid-bit, i.e. every DIV clocks after the start mid-sample.
REQ-028 RX checks only the first stop bit; after sampling it, rx_done pulses and FSM returns to IDLE immediately, ready for a new start edge.
REQ-029 rx_data, rx_frame_err, rx_parity_err SHALL update only in the rx_done cycle; a frame error still delivers rx_data.
REQ-030 Parity bit = XOR of payload, inverted when parity_odd = 1.

Reset
REQ-031 rst_n low SHALL asynchronously force: tx=1, tx_busy=0, tx_done=0, rx_data=0, rx_done=0, rx_frame_err=0, rx_parity_err=0, both FSMs IDLE, counters 0, synchroniser flops 1.
REQ-032 Reset mid-frame SHALL abort both directions with no done pulse; after release TX idles high until a new tx_start.

Configuration
REQ-033 Macro UART_PARITY_EN defined: parity bit transmitted and checked per REQ-030.
REQ-034 Macro undefined: no PARITY state, frame has no parity bit, parity_odd ignored, rx_parity_err tied 0.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, DIV=10, DATA_BITS=8)
REQ-035 TX 0xA5, STOP_BITS=1, no parity: tx = 0,1,0,1,0,0,1,0,1,1 each 10 clocks; tx_done one pulse at cycle 100; tx_busy high 100 cycles.
REQ-036 Loopback tx->rx, 0x3C then 0xC3 back-to-back: two rx_done pulses with rx_data 0x3C, 0xC3; both error flags 0.
REQ-037 rx low pulse of 3 clocks: no rx_done, RX back in IDLE, next valid frame 0x55 received correctly.
REQ-038 Frame 0x81 with stop bit driven 0: rx_done with rx_data=0x81, rx_frame_err=1.
REQ-039 UART_PARITY_EN, parity_odd=0, send 0x07 with parity bit forced 0: rx_parity_err=1; with correct parity 1: rx_parity_err=0.
REQ-040 rst_n low at bit 4 of a TX frame and mid RX frame: tx=1 immediately, no tx_done or rx_done; tx_start 2 cycles after release sends full frame.
